// File: rtl/tlb_pkg.sv
// tlb_pkg: state, PTE-field, flush-mode and access encodings
// shared by the set-associative TLB and its victim selector.
package tlb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    PTW_REQ,
    PTW_WAIT,
    FILL,
    RESPOND,
    FLUSH
  } state_t;

  localparam int PTE_R = 0;
  localparam int PTE_W = 1;
  localparam int PTE_V = 2;
  localparam int PTE_G = 3;

  localparam logic [1:0] FLUSH_ALL  = 2'd0;
  localparam logic [1:0] FLUSH_ASID = 2'd1;
  localparam logic [1:0] FLUSH_VA   = 2'd2;

  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  function automatic logic perm_fault(
    input logic acc,
    input logic r,
    input logic w
  );
    return (acc == ACC_WRITE) ? !w : !r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// tlb_victim_sel: picks the lowest invalid way of a set, or the
// set's round-robin pointer when every way is occupied.
module tlb_victim_sel
  import tlb_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = 2
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    rr,
  output logic [WAY_W-1:0]    victim
);

  always_comb begin
    victim = rr;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) victim = WAY_W'(i);
    end
  end

endmodule

// File: rtl/tlb_assoc.sv
// tlb_assoc: set-associative, ASID-tagged TLB with PTW refill and flush.
// Define TLB_STATS_EN to add saturating hit/miss/fault/flush counters.
module tlb_assoc #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int ASID_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       vaddr_i,
  input  logic              access_type_i,
  input  logic [ASID_W-1:0] asid_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       paddr_o,
  output logic              hit_o,
  output logic              fault_o,
  output logic              ptw_req_valid_o,
  input  logic              ptw_req_ready_i,
  output logic [31:0]       ptw_vaddr_o,
  input  logic              ptw_resp_valid_i,
  output logic              ptw_resp_ready_o,
  input  logic [31:0]       ptw_pte_i,
  input  logic              flush_valid_i,
  output logic              flush_ready_o,
  input  logic [1:0]        flush_mode_i,
  input  logic [ASID_W-1:0] flush_asid_i,
  input  logic [31:0]       flush_vaddr_i
`ifdef TLB_STATS_EN
  ,
  output logic [31:0]       stat_hits_o,
  output logic [31:0]       stat_misses_o,
  output logic [31:0]       stat_faults_o,
  output logic [31:0]       stat_flushes_o
`endif
);

  import tlb_pkg::*;

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  state_t state, next;

  logic [NUM_WAYS-1:0] valid    [NUM_SETS];
  logic [WAY_W-1:0]    rr       [NUM_SETS];
  logic [19:0]         vpn      [NUM_SETS][NUM_WAYS];
  logic [19:0]         ppn      [NUM_SETS][NUM_WAYS];
  logic [ASID_W-1:0]   tag_asid [NUM_SETS][NUM_WAYS];
  logic                glob     [NUM_SETS][NUM_WAYS];
  logic                perm_r   [NUM_SETS][NUM_WAYS];
  logic                perm_w   [NUM_SETS][NUM_WAYS];

  logic [31:0]       va;
  logic              acc;
  logic [ASID_W-1:0] asid;
  logic [19:0]       pte_ppn;
  logic              pte_g, pte_v, pte_r, pte_w;
  logic [1:0]        fmode;
  logic [ASID_W-1:0] fasid;
  logic [IDX_W-1:0]  fcnt;
  logic [31:0]       paddr;
  logic              hit, fault;

  logic [IDX_W-1:0] idx, fidx;
  logic             lk_hit, lk_fault, fill_fault;
  logic [WAY_W-1:0] lk_way, victim;
  logic             unused;

  assign idx    = va[12 +: IDX_W];
  assign fidx   = flush_vaddr_i[12 +: IDX_W];
  assign unused = ^{flush_vaddr_i[11:0], ptw_pte_i[11:4]};

  // Scan high to low so the lowest matching way is the one kept.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid[idx][i] && vpn[idx][i] == va[31:12] &&
          (glob[idx][i] || tag_asid[idx][i] == asid)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(i);
      end
    end
  end

  assign lk_fault   = perm_fault(acc, perm_r[idx][lk_way],
                                 perm_w[idx][lk_way]);
  assign fill_fault = !pte_v || perm_fault(acc, pte_r, pte_w);

  tlb_victim_sel #(
    .NUM_WAYS(NUM_WAYS),
    .WAY_W   (WAY_W)
  ) u_victim (
    .valid (valid[idx]),
    .rr    (rr[idx]),
    .victim(victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (flush_valid_i) begin
          if (flush_mode_i == FLUSH_ALL || flush_mode_i == FLUSH_ASID)
            next = FLUSH;
        end else if (req_valid_i) begin
          next = LOOKUP;
        end
      end
      FLUSH:    if (fcnt == IDX_W'(NUM_SETS - 1)) next = IDLE;
      LOOKUP:   next = lk_hit ? RESPOND : PTW_REQ;
      PTW_REQ:  if (ptw_req_ready_i) next = PTW_WAIT;
      PTW_WAIT: if (ptw_resp_valid_i) next = FILL;
      FILL:     next = RESPOND;
      RESPOND:  if (resp_ready_i) next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      va      <= '0;
      acc     <= 1'b0;
      asid    <= '0;
      pte_ppn <= '0;
      pte_g   <= 1'b0;
      pte_v   <= 1'b0;
      pte_r   <= 1'b0;
      pte_w   <= 1'b0;
      fmode   <= '0;
      fasid   <= '0;
      fcnt    <= '0;
      paddr   <= '0;
      hit     <= 1'b0;
      fault   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_valid_i) begin
            fmode <= flush_mode_i;
            fasid <= flush_asid_i;
            fcnt  <= '0;
          end else if (req_valid_i) begin
            va   <= vaddr_i;
            acc  <= access_type_i;
            asid <= asid_i;
          end
        end
        FLUSH: fcnt <= fcnt + 1'b1;
        LOOKUP: begin
          if (lk_hit) begin
            hit   <= 1'b1;
            fault <= lk_fault;
            paddr <= lk_fault ? '0 : {ppn[idx][lk_way], va[11:0]};
          end
        end
        PTW_WAIT: begin
          if (ptw_resp_valid_i) begin
            pte_ppn <= ptw_pte_i[31:12];
            pte_g   <= ptw_pte_i[PTE_G];
            pte_v   <= ptw_pte_i[PTE_V];
            pte_r   <= ptw_pte_i[PTE_R];
            pte_w   <= ptw_pte_i[PTE_W];
          end
        end
        FILL: begin
          hit   <= 1'b0;
          fault <= fill_fault;
          paddr <= fill_fault ? '0 : {pte_ppn, va[11:0]};
        end
        RESPOND: begin
          if (resp_ready_i) begin
            hit   <= 1'b0;
            fault <= 1'b0;
            paddr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      if (state == IDLE && flush_valid_i && flush_mode_i == FLUSH_VA) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (vpn[fidx][w] == flush_vaddr_i[31:12]) valid[fidx][w] <= 1'b0;
        end
      end
      if (state == FLUSH) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (fmode == FLUSH_ALL ||
              (tag_asid[fcnt][w] == fasid && !glob[fcnt][w]))
            valid[fcnt][w] <= 1'b0;
        end
      end
      if (state == FILL && pte_v) begin
        valid[idx][victim] <= 1'b1;
        rr[idx] <= (rr[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr[idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == FILL && pte_v) begin
      vpn[idx][victim]      <= va[31:12];
      ppn[idx][victim]      <= pte_ppn;
      tag_asid[idx][victim] <= asid;
      glob[idx][victim]     <= pte_g;
      perm_r[idx][victim]   <= pte_r;
      perm_w[idx][victim]   <= pte_w;
    end
  end

  assign req_ready_o      = (state == IDLE);
  assign flush_ready_o    = (state == IDLE);
  assign resp_valid_o     = (state == RESPOND);
  assign ptw_req_valid_o  = (state == PTW_REQ);
  assign ptw_resp_ready_o = (state == PTW_WAIT);
  assign ptw_vaddr_o      = {va[31:12], 12'h000};
  assign paddr_o          = paddr;
  assign hit_o            = hit;
  assign fault_o          = fault;

`ifdef TLB_STATS_EN
  logic [31:0] n_hits, n_misses, n_faults, n_flushes;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_hits    <= '0;
      n_misses  <= '0;
      n_faults  <= '0;
      n_flushes <= '0;
    end else begin
      if (state == LOOKUP && lk_hit)  n_hits   <= sat_inc(n_hits);
      if (state == LOOKUP && !lk_hit) n_misses <= sat_inc(n_misses);
      if ((state == LOOKUP && lk_hit && lk_fault) ||
          (state == FILL && fill_fault))
        n_faults <= sat_inc(n_faults);
      if (state == IDLE && flush_valid_i && flush_mode_i != 2'd3)
        n_flushes <= sat_inc(n_flushes);
    end
  end

  assign stat_hits_o    = n_hits;
  assign stat_misses_o  = n_misses;
  assign stat_faults_o  = n_faults;
  assign stat_flushes_o = n_flushes;
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: table-driven lookups with a response scoreboard,
// plus flush, back-pressure and reset-during-walk sequences.
module tb_tlb_assoc;

  typedef struct {
    logic [31:0] va;
    logic        wr;
    logic [7:0]  asid;
    logic [31:0] pte;
    logic        walk;
    logic [31:0] paddr;
    logic        hit;
    logic        fault;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] vaddr = '0;
  logic        acc = 1'b0;
  logic [7:0]  asid = '0;
  logic        resp_ready = 1'b1;
  logic        ptw_req_ready = 1'b0;
  logic        ptw_resp_valid = 1'b0;
  logic [31:0] ptw_pte = '0;
  logic        flush_valid = 1'b0;
  logic [1:0]  flush_mode = '0;
  logic [7:0]  flush_asid = '0;
  logic [31:0] flush_vaddr = '0;

  logic        req_ready_o, resp_valid_o, hit_o, fault_o;
  logic        ptw_req_valid_o, ptw_resp_ready_o, flush_ready_o;
  logic [31:0] paddr_o, ptw_vaddr_o;

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t tbl [22];

  tlb_assoc dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .vaddr_i         (vaddr),
    .access_type_i   (acc),
    .asid_i          (asid),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready),
    .paddr_o         (paddr_o),
    .hit_o           (hit_o),
    .fault_o         (fault_o),
    .ptw_req_valid_o (ptw_req_valid_o),
    .ptw_req_ready_i (ptw_req_ready),
    .ptw_vaddr_o     (ptw_vaddr_o),
    .ptw_resp_valid_i(ptw_resp_valid),
    .ptw_resp_ready_o(ptw_resp_ready_o),
    .ptw_pte_i       (ptw_pte),
    .flush_valid_i   (flush_valid),
    .flush_ready_o   (flush_ready_o),
    .flush_mode_i    (flush_mode),
    .flush_asid_i    (flush_asid),
    .flush_vaddr_i   (flush_vaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] va, input logic wr, input logic [7:0] as,
    input logic [31:0] pte, input logic walk, input logic [31:0] pa,
    input logic hit, input logic fault);
    vec_t v;
    v.va = va; v.wr = wr; v.asid = as; v.pte = pte;
    v.walk = walk; v.paddr = pa; v.hit = hit; v.fault = fault;
    return v;
  endfunction

  task automatic run_req(input vec_t v, input int stall);
    int   n;
    bit   walked;
    bit   done;
    vec_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    vaddr      = v.va;
    acc        = v.wr;
    asid       = v.asid;
    resp_ready = (stall == 0);
    sb.push_back(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; walked = 0; done = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (ptw_req_valid_o && !walked) begin
        walked = 1;
        chk("ptw_vaddr", ptw_vaddr_o, {v.va[31:12], 12'h000});
        ptw_req_ready = 1'b1;
        @(negedge clk);
        ptw_req_ready  = 1'b0;
        ptw_resp_valid = 1'b1;
        ptw_pte        = v.pte;
        @(negedge clk);
        ptw_resp_valid = 1'b0;
      end else if (resp_valid_o) begin
        done = 1;
        e = sb.pop_front();
        if (!e.walk) chk("hit_latency", n, 2);
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          chk("stall_valid", resp_valid_o, 1'b1);
          chk("stall_paddr", paddr_o, e.paddr);
          chk("stall_hit", hit_o, e.hit);
          chk("stall_fault", fault_o, e.fault);
        end
        chk("paddr", paddr_o, e.paddr);
        chk("hit", hit_o, e.hit);
        chk("fault", fault_o, e.fault);
        resp_ready = 1'b1;
      end
    end
    chk("resp_seen", done, 1'b1);
    chk("walked", walked, v.walk);
    if (done) begin
      @(posedge clk);
      #1;
      if (stall > 0) begin
        chk("post_hs_valid", resp_valid_o, 1'b0);
        chk("post_hs_hit", hit_o, 1'b0);
      end
    end else begin
      sb.delete();
      resp_ready = 1'b1;
    end
  endtask

  task automatic do_flush(input logic [1:0] m, input logic [7:0] fa,
                          input logic [31:0] fva);
    @(negedge clk);
    flush_valid = 1'b1;
    flush_mode  = m;
    flush_asid  = fa;
    flush_vaddr = fva;
    @(posedge clk);
    #1 flush_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int n;

    tbl[0]  = mk(32'h0001_2345, 0, 8'd5, 32'hABCD_E007, 1, 32'hABCD_E345, 0, 0);
    tbl[1]  = mk(32'h0001_2345, 0, 8'd5, 32'h0,        0, 32'hABCD_E345, 1, 0);
    tbl[2]  = mk(32'h0001_2345, 0, 8'd6, 32'hABCD_E00F, 1, 32'hABCD_E345, 0, 0);
    tbl[3]  = mk(32'h0001_2345, 0, 8'd6, 32'h0,        0, 32'hABCD_E345, 1, 0);
    tbl[4]  = mk(32'h0001_2345, 1, 8'd9, 32'h0,        0, 32'hABCD_E345, 1, 0);
    tbl[5]  = mk(32'h0002_5678, 0, 8'd5, 32'h1234_5005, 1, 32'h1234_5678, 0, 0);
    tbl[6]  = mk(32'h0002_5678, 1, 8'd5, 32'h0,        0, 32'h0,         1, 1);
    tbl[7]  = mk(32'h0003_7ABC, 0, 8'd5, 32'h5555_5002, 1, 32'h0,         0, 1);
    tbl[8]  = mk(32'h0003_7ABC, 0, 8'd5, 32'h5555_5002, 1, 32'h0,         0, 1);
    tbl[9]  = mk(32'h0004_7000, 1, 8'd5, 32'h6666_6005, 1, 32'h0,         0, 1);
    tbl[10] = mk(32'h0004_7000, 0, 8'd5, 32'h0,        0, 32'h6666_6000, 1, 0);
    for (int k = 0; k < 5; k++)
      tbl[11+k] = mk(32'h0000_30AB + (32'(k) << 16), 0, 8'd7,
                     {20'h80000 + 20'(k), 12'h007}, 1,
                     {20'h80000 + 20'(k), 12'h0AB}, 0, 0);
    tbl[16] = mk(32'h0004_30AB, 0, 8'd7, 32'h0, 0, 32'h8000_40AB, 1, 0);
    tbl[17] = mk(32'h0002_30AB, 0, 8'd7, 32'h0, 0, 32'h8000_20AB, 1, 0);
    tbl[18] = mk(32'h0003_30AB, 0, 8'd7, 32'h0, 0, 32'h8000_30AB, 1, 0);
    tbl[19] = mk(32'h0000_30AB, 0, 8'd7, 32'h8000_0007, 1, 32'h8000_00AB, 0, 0);
    tbl[20] = mk(32'h0001_30AB, 0, 8'd7, 32'h8000_1007, 1, 32'h8000_10AB, 0, 0);
    tbl[21] = mk(32'h0003_30AB, 0, 8'd7, 32'h0, 0, 32'h8000_30AB, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_flush_ready", flush_ready_o, 1'b1);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_ptw_req_valid", ptw_req_valid_o, 1'b0);
    chk("rst_ptw_resp_ready", ptw_resp_ready_o, 1'b0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_hit", hit_o, 1'b0);
    chk("rst_fault", fault_o, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < $size(tbl); i++) run_req(tbl[i], 0);

    // ASID flush: non-global ASID-5 entries go, ASID-7 and global stay
    do_flush(2'd1, 8'd5, 32'h0);
    busy = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (flush_ready_o) break;
      chk("flush_req_ready_low", req_ready_o, 1'b0);
      busy++;
    end
    chk("flush_busy_cycles", busy, 16);
    run_req(mk(32'h0002_5678, 0, 8'd5, 32'h1234_5007, 1, 32'h1234_5678, 0, 0), 0);
    run_req(mk(32'h0001_2345, 0, 8'd5, 32'h0, 0, 32'hABCD_E345, 1, 0), 0);
    run_req(mk(32'h0004_7000, 0, 8'd5, 32'h6666_6007, 1, 32'h6666_6000, 0, 0), 0);
    run_req(mk(32'h0003_30AB, 0, 8'd7, 32'h0, 0, 32'h8000_30AB, 1, 0), 0);

    // VA flush: only the matching VPN in set 2 disappears
    run_req(mk(32'h0002_2000, 0, 8'd5, 32'h7777_7007, 1, 32'h7777_7000, 0, 0), 0);
    do_flush(2'd2, 8'd0, 32'h0001_2000);
    @(negedge clk);
    chk("va_flush_ready", flush_ready_o, 1'b1);
    run_req(mk(32'h0001_2345, 0, 8'd6, 32'hABCD_E007, 1, 32'hABCD_E345, 0, 0), 0);
    run_req(mk(32'h0002_2ABC, 0, 8'd5, 32'h0, 0, 32'h7777_7ABC, 1, 0), 0);

    // Flush and request together: flush wins, request not taken
    @(negedge clk);
    flush_valid = 1'b1;
    flush_mode  = 2'd2;
    flush_vaddr = 32'h0002_2000;
    req_valid   = 1'b1;
    vaddr       = 32'h0002_2ABC;
    asid        = 8'd5;
    acc         = 1'b0;
    @(posedge clk);
    #1;
    flush_valid = 1'b0;
    req_valid   = 1'b0;
    @(negedge clk);
    chk("collide_req_ready", req_ready_o, 1'b1);
    chk("collide_resp_valid", resp_valid_o, 1'b0);
    run_req(mk(32'h0002_2ABC, 0, 8'd5, 32'h7777_7007, 1, 32'h7777_7ABC, 0, 0), 0);

    // Back-pressure: response held for 5 extra cycles
    run_req(mk(32'h0001_2345, 0, 8'd6, 32'h0, 0, 32'hABCD_E345, 1, 0), 5);

    // Reset while waiting on the walker
    @(negedge clk);
    req_valid = 1'b1;
    vaddr     = 32'h0009_9000;
    asid      = 8'd5;
    acc       = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!ptw_req_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_walk_started", ptw_req_valid_o, 1'b1);
    chk("rst_walk_vaddr", ptw_vaddr_o, 32'h0009_9000);
    ptw_req_ready = 1'b1;
    @(negedge clk);
    ptw_req_ready = 1'b0;
    chk("in_ptw_wait", ptw_resp_ready_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_resp_valid", resp_valid_o, 1'b0);
    chk("rst_wait_req_ready", req_ready_o, 1'b1);
    chk("rst_wait_ptw_ready", ptw_resp_ready_o, 1'b0);
    run_req(mk(32'h0001_2345, 0, 8'd6, 32'hABCD_E007, 1, 32'hABCD_E345, 0, 0), 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
